mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all address channels.
REQ-002 SHALL have parameter DATA_W, default 32, data width; strobe width fixed at 8.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ifu_ar{addr,valid} input ADDR_W/1, ifu_arready output 1: IFU read-address channel (master 0, read-only).
REQ-006 SHALL have ifu_r{data,resp,valid} output DATA_W/2/1, ifu_rready input 1: IFU read-data channel.
REQ-007 SHALL have lsu_ar{addr,valid} input, lsu_arready output: LSU read-address channel (master 1).
REQ-008 SHALL have lsu_r{data,resp,valid} output, lsu_rready input: LSU read-data channel.
REQ-009 SHALL have lsu_aw{addr,valid}, lsu_w{data,strb[8],valid}, lsu_bready input; lsu_awready, lsu_wready, lsu_b{resp,valid} output: LSU write channels.
REQ-010 SHALL have s_* ports mirroring AR/R/AW/W/B toward the single memory slave, direction reversed.

Function
REQ-011 SHALL implement FSM states IDLE, IFU_RD, LSU_RD, LSU_WR; exactly one master granted outside IDLE.
REQ-012 In IDLE, SHALL sample ifu_arvalid, lsu_arvalid, lsu_awvalid; on any asserted, transition next cycle to the winner's state; no slave signal forwarded in IDLE.
REQ-013 Simultaneous requests: default fixed priority LSU_WR > LSU_RD > IFU_RD.
REQ-014 LSU_arvalid and lsu_awvalid both asserted: write wins; read held pending.
REQ-015 While granted, SHALL combinationally connect granted master's channels to s_*; s_*valid outputs 0 for ungranted channels.
REQ-016 Ungranted master SHALL see all ready and valid outputs 0; rdata/bresp outputs SHALL be 0.
REQ-017 IFU_RD/LSU_RD SHALL return to IDLE the cycle after the R handshake (s_rvalid && granted rready).
REQ-018 LSU_WR SHALL track aw_done and w_done flags independently; AW and W handshakes in any order or same cycle; s_awvalid/s_wvalid gated off after own handshake.
REQ-019 LSU_WR SHALL return to IDLE the cycle after B handshake, only after both aw_done and w_done set; a B before both flags SHALL be ignored (not forwarded).
REQ-020 Arbitration latency one cycle; at least one IDLE cycle between consecutive grants.
REQ-021 rresp/bresp forwarded unmodified; non-zero resp SHALL still complete the transaction.
REQ-022 SHALL expose no combinational path from s_*ready to any master valid.

Reset
REQ-023 rst SHALL force state IDLE, clear aw_done/w_done and priority pointer, regardless of in-flight transaction.
REQ-024 During and the cycle after rst, every valid and ready output SHALL be 0.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, IFU vs LSU contention SHALL alternate: a one-bit last-grant pointer favours the master not granted last; LSU write still beats LSU read.
REQ-026 Without ARB_ROUND_ROBIN_EN, fixed priority per REQ-013; pointer logic absent.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold the state enum (arb_state_t), master ID constants (MST_IFU=0, MST_LSU=1), and RESP_OKAY=2'b00.
REQ-028 Sub-module arb_grant (combinational priority/round-robin chooser) SHALL be instantiated once; remaining logic flat.

Verification
REQ-029 IFU read 0x8000_0000, slave arready after 2 cycles, rdata 0x0000_0413 -> ifu_rdata=0x0000_0413, resp 0, FSM back to IDLE one cycle later.
REQ-030 IFU and LSU arvalid same cycle, fixed priority -> LSU granted first, IFU after one IDLE cycle; with ARB_ROUND_ROBIN_EN, repeated contention alternates grants.
REQ-031 LSU write addr 0x8000_0100, data 0xDEAD_BEEF, strb 0x0F, W accepted 3 cycles before AW -> single B forwarded, s_wvalid low after W handshake.
REQ-032 s_bvalid pulsed before AW handshake -> lsu_bvalid stays 0, FSM remains LSU_WR.
REQ-033 rst asserted mid LSU_RD -> next cycle state IDLE, all valid/ready outputs 0, new IFU request granted normally.
REQ-034 Slave returns rresp=2'b10 -> propagated to lsu_rresp, FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: FSM state encoding,
// master identifiers and the AXI OKAY response code.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_t;

    localparam logic       MST_IFU   = 1'b0;
    localparam logic       MST_LSU   = 1'b1;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         STRB_W    = 8;

endpackage

// File: rtl/mem_arbiter_if.sv
// One AXI-lite style memory port (AR/R/AW/W/B). The master modport is the
// requester side, the slave modport the responder side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    // Every channel: a transfer happens on a posedge where valid && ready.
    // Once raised, valid and its payload hold until that transfer; ready may
    // toggle freely and never depends combinationally on the same valid.
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );

endinterface

// File: rtl/arb_grant.sv
// Combinational grant chooser for the memory arbiter. LSU write always beats
// LSU read; IFU vs LSU is fixed (LSU first) unless ARB_ROUND_ROBIN_EN is defined.
module arb_grant
    import mem_arb_pkg::*;
(
    input  logic       ifu_req,
    input  logic       lsu_rd_req,
    input  logic       lsu_wr_req,
    input  logic       prio_ifu,
    output arb_state_t grant
);

    arb_state_t lsu_pick;

    assign lsu_pick = lsu_wr_req ? LSU_WR : (lsu_rd_req ? LSU_RD : IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    // prio_ifu is set when the LSU held the previous grant.
    always_comb begin
        grant = lsu_pick;
        if (ifu_req && (prio_ifu || lsu_pick == IDLE)) begin
            grant = IFU_RD;
        end
    end
`else
    logic unused_prio;
    assign unused_prio = prio_ifu;

    always_comb begin
        grant = IDLE;
        if (lsu_pick != IDLE) begin
            grant = lsu_pick;
        end else if (ifu_req) begin
            grant = IFU_RD;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU reads, LSU reads and LSU writes onto a single memory slave.
// Define ARB_ROUND_ROBIN_EN to alternate IFU/LSU grants under contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  ifu,
    mem_arbiter_if.slave  lsu,
    mem_arbiter_if.master s,
    output arb_state_t    dbg_state
);

    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    arb_state_t        state;
    arb_state_t        next_grant;
    logic              aw_done;
    logic              w_done;
    logic              prio_ifu;
    logic              gnt_ifu;
    logic              gnt_lsu_rd;
    logic              gnt_lsu_wr;
    logic              b_open;
    logic              r_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic [ADDR_W-1:0] ar_addr_sel;
    logic              unused_ifu_wr;

    assign unused_ifu_wr = ^{ifu.awaddr, ifu.awvalid, ifu.wdata, ifu.wstrb,
                             ifu.wvalid, ifu.bready};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_lsu;
    assign prio_ifu = (last_lsu == MST_LSU);
`else
    assign prio_ifu = 1'b0;
`endif

    arb_grant u_grant (
        .ifu_req   (ifu.arvalid),
        .lsu_rd_req(lsu.arvalid),
        .lsu_wr_req(lsu.awvalid),
        .prio_ifu  (prio_ifu),
        .grant     (next_grant)
    );

    // Grants are masked by rst so every valid/ready is low while reset is held.
    assign gnt_ifu    = !rst && (state == IFU_RD);
    assign gnt_lsu_rd = !rst && (state == LSU_RD);
    assign gnt_lsu_wr = !rst && (state == LSU_WR);
    assign b_open     = gnt_lsu_wr && aw_done && w_done;

    // Read address / data
    assign ar_addr_sel = gnt_lsu_rd ? lsu.araddr : ifu.araddr;
    assign s.araddr    = ar_addr_sel;
    assign s.arvalid   = (gnt_ifu && ifu.arvalid) || (gnt_lsu_rd && lsu.arvalid);
    assign ifu.arready = gnt_ifu && s.arready;
    assign lsu.arready = gnt_lsu_rd && s.arready;
    assign s.rready    = (gnt_ifu && ifu.rready) || (gnt_lsu_rd && lsu.rready);
    assign ifu.rvalid  = gnt_ifu && s.rvalid;
    assign ifu.rdata   = gnt_ifu ? s.rdata : DATA_ZERO;
    assign ifu.rresp   = gnt_ifu ? s.rresp : 2'b00;
    assign lsu.rvalid  = gnt_lsu_rd && s.rvalid;
    assign lsu.rdata   = gnt_lsu_rd ? s.rdata : DATA_ZERO;
    assign lsu.rresp   = gnt_lsu_rd ? s.rresp : 2'b00;

    // Write: each of AW and W is forwarded only until its own handshake.
    assign s.awaddr    = lsu.awaddr;
    assign s.awvalid   = gnt_lsu_wr && !aw_done && lsu.awvalid;
    assign lsu.awready = gnt_lsu_wr && !aw_done && s.awready;
    assign s.wdata     = lsu.wdata;
    assign s.wstrb     = lsu.wstrb;
    assign s.wvalid    = gnt_lsu_wr && !w_done && lsu.wvalid;
    assign lsu.wready  = gnt_lsu_wr && !w_done && s.wready;
    assign lsu.bvalid  = b_open && s.bvalid;
    assign lsu.bresp   = b_open ? s.bresp : 2'b00;
    assign s.bready    = b_open && lsu.bready;

    // The IFU never writes.
    assign ifu.awready = 1'b0;
    assign ifu.wready  = 1'b0;
    assign ifu.bvalid  = 1'b0;
    assign ifu.bresp   = 2'b00;

    assign r_hs  = s.rvalid && s.rready;
    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid && s.wready;
    assign b_hs  = s.bvalid && s.bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu <= MST_IFU;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= next_grant;
`ifdef ARB_ROUND_ROBIN_EN
                    if (next_grant != IDLE) begin
                        last_lsu <= (next_grant == IFU_RD) ? MST_IFU : MST_LSU;
                    end
`endif
                end
                IFU_RD, LSU_RD: begin
                    if (r_hs) begin
                        state <= IDLE;
                    end
                end
                LSU_WR: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (b_hs) begin
                        state   <= IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, IFU read, contention, write ordering,
// early B, mid-transaction reset and error response propagation.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clk;
    logic       rst;
    arb_state_t dbg_state;
    int         n_tests;
    int         n_fail;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .ifu      (ifu_bus),
        .lsu      (lsu_bus),
        .s        (mem_bus),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [14:0] vr_outs();
        return {ifu_bus.arready, ifu_bus.rvalid, ifu_bus.awready, ifu_bus.wready,
                ifu_bus.bvalid, lsu_bus.arready, lsu_bus.rvalid, lsu_bus.awready,
                lsu_bus.wready, lsu_bus.bvalid, mem_bus.arvalid, mem_bus.rready,
                mem_bus.awvalid, mem_bus.wvalid, mem_bus.bready};
    endfunction

    // driver tasks
    task automatic idle_inputs();
        ifu_bus.araddr = '0; ifu_bus.arvalid = 0; ifu_bus.rready = 0;
        ifu_bus.awaddr = '0; ifu_bus.awvalid = 0; ifu_bus.wdata = '0;
        ifu_bus.wstrb = '0; ifu_bus.wvalid = 0; ifu_bus.bready = 0;
        lsu_bus.araddr = '0; lsu_bus.arvalid = 0; lsu_bus.rready = 0;
        lsu_bus.awaddr = '0; lsu_bus.awvalid = 0; lsu_bus.wdata = '0;
        lsu_bus.wstrb = '0; lsu_bus.wvalid = 0; lsu_bus.bready = 0;
        mem_bus.arready = 0; mem_bus.rdata = '0; mem_bus.rresp = '0;
        mem_bus.rvalid = 0; mem_bus.awready = 0; mem_bus.wready = 0;
        mem_bus.bresp = '0; mem_bus.bvalid = 0;
    endtask

    // One read transaction, starting the negedge after the grant edge.
    task automatic do_read(input arb_state_t exp_st, input logic [31:0] exp_addr,
                           input int ar_wait, input logic [31:0] rd,
                           input logic [1:0] rr, input logic keep_req);
        logic is_ifu;
        is_ifu = (exp_st == IFU_RD);
        @(negedge clk);
        n_tests++;
        if (dbg_state !== exp_st) begin
            n_fail++;
            $display("FAIL rd_grant: state %0d, expected %0d", dbg_state, exp_st);
        end
        n_tests++;
        if (mem_bus.arvalid !== 1'b1 || mem_bus.araddr !== exp_addr) begin
            n_fail++;
            $display("FAIL rd_ar_fwd: arvalid %b araddr %h, expected 1 %h",
                     mem_bus.arvalid, mem_bus.araddr, exp_addr);
        end
        for (int i = 0; i < ar_wait; i++) begin
            n_tests++;
            if (ifu_bus.arready !== 1'b0 || lsu_bus.arready !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_ar_wait: arready ifu %b lsu %b, expected 0 0",
                         ifu_bus.arready, lsu_bus.arready);
            end
            @(negedge clk);
        end
        mem_bus.arready = 1'b1;
        #1;
        n_tests++;
        if ({ifu_bus.arready, lsu_bus.arready} !== (is_ifu ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rd_arready: ifu/lsu %b%b, expected %b",
                     ifu_bus.arready, lsu_bus.arready, is_ifu ? 2'b10 : 2'b01);
        end
        @(negedge clk);
        mem_bus.arready = 1'b0;
        if (!keep_req) begin
            if (is_ifu) ifu_bus.arvalid = 1'b0;
            else        lsu_bus.arvalid = 1'b0;
        end
        mem_bus.rvalid = 1'b1; mem_bus.rdata = rd; mem_bus.rresp = rr;
        ifu_bus.rready = 1'b1; lsu_bus.rready = 1'b1;
        #1;
        n_tests++;
        if ({ifu_bus.rvalid, lsu_bus.rvalid} !== (is_ifu ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rd_rvalid: ifu/lsu %b%b, expected %b",
                     ifu_bus.rvalid, lsu_bus.rvalid, is_ifu ? 2'b10 : 2'b01);
        end
        n_tests++;
        if (is_ifu ? (ifu_bus.rdata !== rd || ifu_bus.rresp !== rr ||
                      lsu_bus.rdata !== 32'h0 || lsu_bus.rresp !== 2'b00)
                   : (lsu_bus.rdata !== rd || lsu_bus.rresp !== rr ||
                      ifu_bus.rdata !== 32'h0 || ifu_bus.rresp !== 2'b00)) begin
            n_fail++;
            $display("FAIL rd_data: ifu %h/%b lsu %h/%b, expected granted %h/%b other 0",
                     ifu_bus.rdata, ifu_bus.rresp, lsu_bus.rdata, lsu_bus.rresp, rd, rr);
        end
        @(negedge clk);
        n_tests++;
        if (dbg_state !== IDLE || mem_bus.arvalid !== 1'b0 ||
            ifu_bus.rvalid !== 1'b0 || lsu_bus.rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done: state %0d s_arvalid %b rvalid %b%b, expected 0 0 00",
                     dbg_state, mem_bus.arvalid, ifu_bus.rvalid, lsu_bus.rvalid);
        end
        mem_bus.rvalid = 1'b0; mem_bus.rdata = '0; mem_bus.rresp = '0;
        ifu_bus.rready = 1'b0; lsu_bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_tests++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: state %0d, expected %0d", dbg_state, IDLE);
        end
        n_tests++;
        if (vr_outs() !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_outs: %b, expected 0", vr_outs());
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (vr_outs() !== 15'h0) begin
            n_fail++;
            $display("FAIL reset_after_outs: %b, expected 0", vr_outs());
        end
    endtask

    task automatic test_ifu_read();
        ifu_bus.araddr = 32'h8000_0000;
        ifu_bus.arvalid = 1'b1;
        do_read(IFU_RD, 32'h8000_0000, 2, 32'h0000_0413, RESP_OKAY, 1'b0);
    endtask

    task automatic test_priority();
        ifu_bus.araddr = 32'h8000_1000; ifu_bus.arvalid = 1'b1;
        lsu_bus.araddr = 32'h8000_2000; lsu_bus.arvalid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        do_read(LSU_RD, 32'h8000_2000, 0, 32'h0000_00A1, RESP_OKAY, 1'b1);
        do_read(IFU_RD, 32'h8000_1000, 0, 32'h0000_00A2, RESP_OKAY, 1'b0);
        do_read(LSU_RD, 32'h8000_2000, 0, 32'h0000_00A3, RESP_OKAY, 1'b0);
`else
        do_read(LSU_RD, 32'h8000_2000, 0, 32'h0000_00A1, RESP_OKAY, 1'b1);
        do_read(LSU_RD, 32'h8000_2000, 0, 32'h0000_00A3, RESP_OKAY, 1'b0);
        do_read(IFU_RD, 32'h8000_1000, 0, 32'h0000_00A2, RESP_OKAY, 1'b0);
`endif
    endtask

    task automatic test_write_w_first();
        lsu_bus.awaddr = 32'h8000_0100; lsu_bus.awvalid = 1'b1;
        lsu_bus.wdata = 32'hDEAD_BEEF; lsu_bus.wstrb = 8'h0F; lsu_bus.wvalid = 1'b1;
        lsu_bus.bready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dbg_state !== LSU_WR) begin
            n_fail++;
            $display("FAIL wr_grant: state %0d, expected %0d", dbg_state, LSU_WR);
        end
        n_tests++;
        if (mem_bus.awvalid !== 1'b1 || mem_bus.awaddr !== 32'h8000_0100 ||
            mem_bus.wvalid !== 1'b1 || mem_bus.wdata !== 32'hDEAD_BEEF ||
            mem_bus.wstrb !== 8'h0F) begin
            n_fail++;
            $display("FAIL wr_fwd: aw %b %h w %b %h %h, expected 1 80000100 1 deadbeef 0f",
                     mem_bus.awvalid, mem_bus.awaddr, mem_bus.wvalid, mem_bus.wdata, mem_bus.wstrb);
        end
        mem_bus.wready = 1'b1;
        #1;
        n_tests++;
        if (lsu_bus.wready !== 1'b1 || lsu_bus.awready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_wready: wready %b awready %b, expected 1 0",
                     lsu_bus.wready, lsu_bus.awready);
        end
        @(negedge clk);
        mem_bus.wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (mem_bus.wvalid !== 1'b0 || mem_bus.awvalid !== 1'b1 || dbg_state !== LSU_WR) begin
                n_fail++;
                $display("FAIL wr_w_gated: s_wvalid %b s_awvalid %b state %0d, expected 0 1 %0d",
                         mem_bus.wvalid, mem_bus.awvalid, dbg_state, LSU_WR);
            end
            if (i == 2) mem_bus.awready = 1'b1;
            @(negedge clk);
        end
        mem_bus.awready = 1'b0;
        lsu_bus.awvalid = 1'b0; lsu_bus.wvalid = 1'b0;
        mem_bus.bvalid = 1'b1; mem_bus.bresp = RESP_OKAY;
        #1;
        n_tests++;
        if (mem_bus.awvalid !== 1'b0 || lsu_bus.bvalid !== 1'b1 || lsu_bus.bresp !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL wr_b_fwd: s_awvalid %b bvalid %b bresp %b, expected 0 1 00",
                     mem_bus.awvalid, lsu_bus.bvalid, lsu_bus.bresp);
        end
        @(negedge clk);
        n_tests++;
        if (dbg_state !== IDLE || lsu_bus.bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: state %0d bvalid %b, expected 0 0", dbg_state, lsu_bus.bvalid);
        end
        mem_bus.bvalid = 1'b0; lsu_bus.bready = 1'b0;
    endtask

    task automatic test_write_beats_read();
        lsu_bus.araddr = 32'h8000_0200; lsu_bus.arvalid = 1'b1;
        lsu_bus.awaddr = 32'h8000_0204; lsu_bus.awvalid = 1'b1;
        lsu_bus.wdata = 32'h1357_9BDF; lsu_bus.wstrb = 8'hFF; lsu_bus.wvalid = 1'b1;
        lsu_bus.bready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dbg_state !== LSU_WR || mem_bus.arvalid !== 1'b0 || lsu_bus.arready !== 1'b0) begin
            n_fail++;
            $display("FAIL wbr_grant: state %0d s_arvalid %b arready %b, expected %0d 0 0",
                     dbg_state, mem_bus.arvalid, lsu_bus.arready, LSU_WR);
        end
        mem_bus.bvalid = 1'b1; mem_bus.bresp = 2'b11;
        #1;
        n_tests++;
        if (lsu_bus.bvalid !== 1'b0 || mem_bus.bready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_b_fwd: bvalid %b s_bready %b, expected 0 0",
                     lsu_bus.bvalid, mem_bus.bready);
        end
        @(negedge clk);
        n_tests++;
        if (dbg_state !== LSU_WR || lsu_bus.bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL early_b_state: state %0d bvalid %b, expected %0d 0",
                     dbg_state, lsu_bus.bvalid, LSU_WR);
        end
        mem_bus.bvalid = 1'b0;
        mem_bus.awready = 1'b1; mem_bus.wready = 1'b1;
        @(negedge clk);
        mem_bus.awready = 1'b0; mem_bus.wready = 1'b0;
        lsu_bus.awvalid = 1'b0; lsu_bus.wvalid = 1'b0;
        mem_bus.bvalid = 1'b1; mem_bus.bresp = 2'b11;
        #1;
        n_tests++;
        if (lsu_bus.bvalid !== 1'b1 || lsu_bus.bresp !== 2'b11) begin
            n_fail++;
            $display("FAIL wbr_b_fwd: bvalid %b bresp %b, expected 1 11",
                     lsu_bus.bvalid, lsu_bus.bresp);
        end
        @(negedge clk);
        n_tests++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL wbr_done: state %0d, expected 0", dbg_state);
        end
        mem_bus.bvalid = 1'b0; mem_bus.bresp = '0; lsu_bus.bready = 1'b0;
        do_read(LSU_RD, 32'h8000_0200, 0, 32'hCAFE_0001, 2'b10, 1'b0);
    endtask

    task automatic test_reset_mid();
        lsu_bus.araddr = 32'h8000_0300; lsu_bus.arvalid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (dbg_state !== LSU_RD) begin
            n_fail++;
            $display("FAIL rmid_grant: state %0d, expected %0d", dbg_state, LSU_RD);
        end
        rst = 1'b1;
        lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b1;
        mem_bus.arready = 1'b1; mem_bus.rvalid = 1'b1;
        #1;
        n_tests++;
        if (vr_outs() !== 15'h0) begin
            n_fail++;
            $display("FAIL rmid_during: %b, expected 0", vr_outs());
        end
        @(negedge clk);
        n_tests++;
        if (dbg_state !== IDLE || vr_outs() !== 15'h0) begin
            n_fail++;
            $display("FAIL rmid_idle: state %0d outs %b, expected 0 0", dbg_state, vr_outs());
        end
        rst = 1'b0;
        lsu_bus.rready = 1'b0; mem_bus.arready = 1'b0; mem_bus.rvalid = 1'b0;
        ifu_bus.araddr = 32'h8000_0040; ifu_bus.arvalid = 1'b1;
        #1;
        n_tests++;
        if (vr_outs() !== 15'h0) begin
            n_fail++;
            $display("FAIL rmid_after: %b, expected 0", vr_outs());
        end
        do_read(IFU_RD, 32'h8000_0040, 0, 32'h1234_5678, RESP_OKAY, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle_inputs();
        test_reset();
        test_ifu_read();
        test_priority();
        test_write_w_first();
        test_write_beats_read();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
